// File: rtl/mips_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mips_bus_arbiter
//
// Shares one Avalon-style memory bus between the two CPU masters:
//   m0 = instruction fetch, m1 = data load/store.
// Only one transaction is on the slave bus at a time. Ties between the
// masters go round-robin (FIXED_PRIO = 0) or always to m0 (FIXED_PRIO = 1).
//
// Transaction flow:
//   IDLE  : sample requests, latch the winner's address/data/strobes.
//   BUS   : slave strobes asserted. A write completes in the cycle the slave
//           drops waitrequest (master waitrequest low that same cycle).
//           A read moves on to RDATA once accepted.
//   RDATA : slave readdata is forwarded to the owner with waitrequest low.
//   ABORT : the slave stalled WAIT_TIMEOUT cycles; strobes are dropped, the
//           owner is released with readdata = 0 and bus_error is set.
//
// Ports
//   clk, reset                      clock (rising edge), async active-high reset
//   m0_* / m1_*                     master side: read, write, address,
//                                   writedata, byteenable in;
//                                   waitrequest, readdata out
//   address, read, write,
//   writedata, byteenable           slave side outputs (registered)
//   waitrequest, readdata           slave side inputs
//   grant                           one-hot current owner, 00 when idle
//   bus_error                       sticky timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module mips_bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int FIXED_PRIO   = 0,
    parameter int WAIT_TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,

    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,

    output logic [ADDR_W-1:0]   address,
    output logic                read,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    output logic [DATA_W/8-1:0] byteenable,
    input  logic                waitrequest,
    input  logic [DATA_W-1:0]   readdata,

    output logic [1:0]          grant,
    output logic                bus_error
);

    localparam int BE_W  = DATA_W / 8;
    // The stall counter only needs to reach WAIT_TIMEOUT-1: the abort fires
    // on the stall cycle that would make it WAIT_TIMEOUT.
    localparam int CNT_W = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);
    localparam bit   ROUND_ROBIN = (FIXED_PRIO == 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        RDATA = 2'd2,
        ABORT = 2'd3
    } state_t;

    state_t              state_reg;
    logic                rr_reg;          // 1 = m1 wins the next tie
    logic                read_reg;
    logic                write_reg;
    logic [ADDR_W-1:0]   address_reg;
    logic [DATA_W-1:0]   writedata_reg;
    logic [BE_W-1:0]     byteenable_reg;
    logic [1:0]          grant_reg;
    logic                bus_error_reg;
    logic [CNT_W-1:0]    cnt_reg;

    // ------------------------------------------------------------------
    // Request selection (used only in IDLE)
    // ------------------------------------------------------------------
    logic                any_req;
    logic                pick_m1;
    logic                pick_read;
    logic                pick_write;
    logic [ADDR_W-1:0]   pick_address;
    logic [DATA_W-1:0]   pick_writedata;
    logic [BE_W-1:0]     pick_byteenable;
    logic [1:0]          req;

    assign req[0] = m0_read | m0_write;
    assign req[1] = m1_read | m1_write;
    assign any_req = req[0] | req[1];

    // m1 wins when it is alone, or on a tie when round-robin favours it.
    assign pick_m1 = req[1] & (~req[0] | (ROUND_ROBIN & rr_reg));

    assign pick_read       = pick_m1 ? m1_read       : m0_read;
    assign pick_write      = pick_m1 ? m1_write      : m0_write;
    assign pick_address    = pick_m1 ? m1_address    : m0_address;
    assign pick_writedata  = pick_m1 ? m1_writedata  : m0_writedata;
    assign pick_byteenable = pick_m1 ? m1_byteenable : m0_byteenable;

    // ------------------------------------------------------------------
    // Control FSM and registered slave-side outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            rr_reg         <= 1'b0;
            read_reg       <= 1'b0;
            write_reg      <= 1'b0;
            address_reg    <= '0;
            writedata_reg  <= '0;
            byteenable_reg <= '0;
            grant_reg      <= 2'b00;
            bus_error_reg  <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        grant_reg      <= pick_m1 ? 2'b10 : 2'b01;
                        rr_reg         <= ~pick_m1;
                        // A master raising both strobes gets a write only.
                        write_reg      <= pick_write;
                        read_reg       <= pick_read & ~pick_write;
                        address_reg    <= pick_address;
                        writedata_reg  <= pick_writedata;
                        byteenable_reg <= pick_byteenable;
                        cnt_reg        <= '0;
                        state_reg      <= BUS;
                    end
                end

                BUS: begin
                    if (!waitrequest) begin
                        read_reg  <= 1'b0;
                        write_reg <= 1'b0;
                        cnt_reg   <= '0;
                        if (write_reg) begin
                            grant_reg <= 2'b00;
                            state_reg <= IDLE;
                        end else begin
                            state_reg <= RDATA;
                        end
                    end else if (cnt_reg == CNT_LAST) begin
                        read_reg      <= 1'b0;
                        write_reg     <= 1'b0;
                        cnt_reg       <= '0;
                        bus_error_reg <= 1'b1;
                        state_reg     <= ABORT;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                RDATA, ABORT: begin
                    grant_reg <= 2'b00;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Master-side responses
    // ------------------------------------------------------------------
    // The write completion has to be visible in the same cycle the slave
    // accepts, so it is decoded from the live slave waitrequest.
    logic done;
    assign done = (state_reg == BUS && write_reg && !waitrequest) ||
                  (state_reg == RDATA) ||
                  (state_reg == ABORT);

    logic              m_waitrequest [2];
    logic [DATA_W-1:0] m_readdata    [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            assign m_waitrequest[gi] = ~(grant_reg[gi] & done);
            // Only RDATA forwards slave data; ABORT returns zero.
            assign m_readdata[gi] = (grant_reg[gi] && state_reg == RDATA) ? readdata : '0;
        end
    endgenerate

    assign m0_waitrequest = m_waitrequest[0];
    assign m1_waitrequest = m_waitrequest[1];
    assign m0_readdata    = m_readdata[0];
    assign m1_readdata    = m_readdata[1];

    assign address    = address_reg;
    assign read       = read_reg;
    assign write      = write_reg;
    assign writedata  = writedata_reg;
    assign byteenable = byteenable_reg;
    assign grant      = grant_reg;
    assign bus_error  = bus_error_reg;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mips_bus_arbiter
//
// Two arbiters share all inputs: dut (round-robin) and dut_fp (fixed
// priority), both with WAIT_TIMEOUT = 8. A table of per-cycle vectors
// drives the masters and slave, followed by hand sequences for timeout and
// reset during RDATA. Inputs change 1 time unit after the rising edge and
// outputs are checked 1 time unit later.
// ---------------------------------------------------------------------------
module tb_mips_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic [31:0] address, writedata;
    logic        read, write;
    logic [3:0]  byteenable;
    logic [1:0]  grant;
    logic        bus_error;

    logic        fp_m0_waitrequest, fp_m1_waitrequest;
    logic [31:0] fp_m0_readdata, fp_m1_readdata;
    logic [31:0] fp_address, fp_writedata;
    logic        fp_read, fp_write;
    logic [3:0]  fp_byteenable;
    logic [1:0]  fp_grant;
    logic        fp_bus_error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0), .WAIT_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .address(address), .read(read), .write(write), .writedata(writedata),
        .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata),
        .grant(grant), .bus_error(bus_error)
    );

    mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1), .WAIT_TIMEOUT(8)) dut_fp (
        .clk(clk), .reset(reset),
        .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(fp_m0_waitrequest), .m0_readdata(fp_m0_readdata),
        .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(fp_m1_waitrequest), .m1_readdata(fp_m1_readdata),
        .address(fp_address), .read(fp_read), .write(fp_write), .writedata(fp_writedata),
        .byteenable(fp_byteenable), .waitrequest(waitrequest), .readdata(readdata),
        .grant(fp_grant), .bus_error(fp_bus_error)
    );

    // req   = {m0_read, m0_write, m1_read, m1_write}
    // flags = expected {read, write, m0_waitrequest, m1_waitrequest}
    // bus   = 0 no bus-field check, 1 expect m0 fields, 2 expect m1 fields
    typedef struct {
        logic [3:0]  req;
        logic        swait;
        logic [31:0] rdata;
        logic [3:0]  flags;
        logic [1:0]  egrant;
        logic [1:0]  efp_grant;
        logic [31:0] em0_rdata;
        logic [31:0] em1_rdata;
        logic [1:0]  bus;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        m0_read       = 1'b0;
        m0_write      = 1'b0;
        m1_read       = 1'b0;
        m1_write      = 1'b0;
        m0_address    = 32'hBFC0_0000;
        m1_address    = 32'hBFC0_0108;
        m0_writedata  = 32'h1234_5678;
        m1_writedata  = 32'h0000_00FF;
        m0_byteenable = 4'b1100;
        m1_byteenable = 4'b1111;
        waitrequest   = 1'b0;
        readdata      = 32'hDEAD_BEEF;

        // Both masters reading continuously: rr alternates, fixed stays on m0.
        tbl.push_back('{4'b1010, 1'b0, 32'hDEAD_BEEF, 4'b0011, 2'b00, 2'b00, 32'h0, 32'h0, 2'd0});
        tbl.push_back('{4'b1010, 1'b0, 32'hDEAD_BEEF, 4'b1011, 2'b01, 2'b01, 32'h0, 32'h0, 2'd1});
        tbl.push_back('{4'b1010, 1'b0, 32'hA0A0_A0A0, 4'b0001, 2'b01, 2'b01, 32'hA0A0_A0A0, 32'h0, 2'd0});
        tbl.push_back('{4'b1010, 1'b0, 32'hDEAD_BEEF, 4'b0011, 2'b00, 2'b00, 32'h0, 32'h0, 2'd0});
        tbl.push_back('{4'b1010, 1'b0, 32'hDEAD_BEEF, 4'b1011, 2'b10, 2'b01, 32'h0, 32'h0, 2'd2});
        tbl.push_back('{4'b1010, 1'b0, 32'hA1A1_A1A1, 4'b0010, 2'b10, 2'b01, 32'h0, 32'hA1A1_A1A1, 2'd0});
        tbl.push_back('{4'b1010, 1'b0, 32'hDEAD_BEEF, 4'b0011, 2'b00, 2'b00, 32'h0, 32'h0, 2'd0});
        tbl.push_back('{4'b1010, 1'b0, 32'hDEAD_BEEF, 4'b1011, 2'b01, 2'b01, 32'h0, 32'h0, 2'd1});
        tbl.push_back('{4'b1010, 1'b0, 32'hA2A2_A2A2, 4'b0001, 2'b01, 2'b01, 32'hA2A2_A2A2, 32'h0, 2'd0});
        tbl.push_back('{4'b1010, 1'b0, 32'hDEAD_BEEF, 4'b0011, 2'b00, 2'b00, 32'h0, 32'h0, 2'd0});
        tbl.push_back('{4'b1010, 1'b0, 32'hDEAD_BEEF, 4'b1011, 2'b10, 2'b01, 32'h0, 32'h0, 2'd2});
        tbl.push_back('{4'b1010, 1'b0, 32'hA3A3_A3A3, 4'b0010, 2'b10, 2'b01, 32'h0, 32'hA3A3_A3A3, 2'd0});
        tbl.push_back('{4'b0000, 1'b0, 32'hDEAD_BEEF, 4'b0011, 2'b00, 2'b00, 32'h0, 32'h0, 2'd0});
        // m1 write, zero wait: write=1 on cycle 2 with m1_waitrequest low.
        tbl.push_back('{4'b0001, 1'b0, 32'hDEAD_BEEF, 4'b0011, 2'b00, 2'b00, 32'h0, 32'h0, 2'd0});
        tbl.push_back('{4'b0001, 1'b0, 32'hDEAD_BEEF, 4'b0110, 2'b10, 2'b10, 32'h0, 32'h0, 2'd2});
        // m0 read, data 0x11 returned in cycle 3.
        tbl.push_back('{4'b1000, 1'b0, 32'hDEAD_BEEF, 4'b0011, 2'b00, 2'b00, 32'h0, 32'h0, 2'd0});
        tbl.push_back('{4'b1000, 1'b0, 32'hDEAD_BEEF, 4'b1011, 2'b01, 2'b01, 32'h0, 32'h0, 2'd1});
        tbl.push_back('{4'b1000, 1'b0, 32'h0000_0011, 4'b0001, 2'b01, 2'b01, 32'h0000_0011, 32'h0, 2'd0});
        // m1 write with the slave stalling five cycles.
        tbl.push_back('{4'b0001, 1'b1, 32'hDEAD_BEEF, 4'b0011, 2'b00, 2'b00, 32'h0, 32'h0, 2'd0});
        for (int i = 0; i < 5; i++)
            tbl.push_back('{4'b0001, 1'b1, 32'hDEAD_BEEF, 4'b0111, 2'b10, 2'b10, 32'h0, 32'h0, 2'd2});
        tbl.push_back('{4'b0001, 1'b0, 32'hDEAD_BEEF, 4'b0110, 2'b10, 2'b10, 32'h0, 32'h0, 2'd2});
        tbl.push_back('{4'b0000, 1'b0, 32'hDEAD_BEEF, 4'b0011, 2'b00, 2'b00, 32'h0, 32'h0, 2'd0});
        // m0 raising read and write together: write wins.
        tbl.push_back('{4'b1100, 1'b0, 32'hDEAD_BEEF, 4'b0011, 2'b00, 2'b00, 32'h0, 32'h0, 2'd0});
        tbl.push_back('{4'b1100, 1'b0, 32'hDEAD_BEEF, 4'b0101, 2'b01, 2'b01, 32'h0, 32'h0, 2'd1});
        tbl.push_back('{4'b0000, 1'b0, 32'hDEAD_BEEF, 4'b0011, 2'b00, 2'b00, 32'h0, 32'h0, 2'd0});

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("rst_read",      32'(read), 32'h0);
        chk("rst_write",     32'(write), 32'h0);
        chk("rst_address",   address, 32'h0);
        chk("rst_writedata", writedata, 32'h0);
        chk("rst_be",        32'(byteenable), 32'h0);
        chk("rst_m0_wait",   32'(m0_waitrequest), 32'h1);
        chk("rst_m1_wait",   32'(m1_waitrequest), 32'h1);
        chk("rst_m0_rdata",  m0_readdata, 32'h0);
        chk("rst_m1_rdata",  m1_readdata, 32'h0);
        chk("rst_grant",     32'(grant), 32'h0);
        chk("rst_bus_error", 32'(bus_error), 32'h0);
        $display("reset: grant=%b bus_error=%b", grant, bus_error);
        reset = 1'b0;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            tick;
            {m0_read, m0_write, m1_read, m1_write} = tbl[i].req;
            waitrequest = tbl[i].swait;
            readdata    = tbl[i].rdata;
            #1;
            chk($sformatf("row%0d_read", i),     32'(read), 32'(tbl[i].flags[3]));
            chk($sformatf("row%0d_write", i),    32'(write), 32'(tbl[i].flags[2]));
            chk($sformatf("row%0d_m0_wait", i),  32'(m0_waitrequest), 32'(tbl[i].flags[1]));
            chk($sformatf("row%0d_m1_wait", i),  32'(m1_waitrequest), 32'(tbl[i].flags[0]));
            chk($sformatf("row%0d_grant", i),    32'(grant), 32'(tbl[i].egrant));
            chk($sformatf("row%0d_fp_grant", i), 32'(fp_grant), 32'(tbl[i].efp_grant));
            chk($sformatf("row%0d_m0_rdata", i), m0_readdata, tbl[i].em0_rdata);
            chk($sformatf("row%0d_m1_rdata", i), m1_readdata, tbl[i].em1_rdata);
            if (tbl[i].bus == 2'd1) begin
                chk($sformatf("row%0d_address", i),   address, 32'hBFC0_0000);
                chk($sformatf("row%0d_writedata", i), writedata, 32'h1234_5678);
                chk($sformatf("row%0d_be", i),        32'(byteenable), 32'hC);
            end else if (tbl[i].bus == 2'd2) begin
                chk($sformatf("row%0d_address", i),   address, 32'hBFC0_0108);
                chk($sformatf("row%0d_writedata", i), writedata, 32'h0000_00FF);
                chk($sformatf("row%0d_be", i),        32'(byteenable), 32'hF);
            end
            $display("row %0d: req=%b wait=%b rd=%b wr=%b grant=%b fp_grant=%b m0w=%b m1w=%b",
                     i, tbl[i].req, waitrequest, read, write, grant, fp_grant,
                     m0_waitrequest, m1_waitrequest);
        end

        // ---------------- timeout: m1 read, slave stuck ----------------
        tick;
        m1_read     = 1'b1;
        waitrequest = 1'b1;
        readdata    = 32'hFFFF_FFFF;
        #1;
        chk("to_idle_grant", 32'(grant), 32'h0);
        for (int k = 1; k <= 8; k++) begin
            tick;
            chk($sformatf("to_stall%0d_read", k),  32'(read), 32'h1);
            chk($sformatf("to_stall%0d_m1w", k),   32'(m1_waitrequest), 32'h1);
            chk($sformatf("to_stall%0d_err", k),   32'(bus_error), 32'h0);
        end
        tick;
        chk("to_abort_read",    32'(read), 32'h0);
        chk("to_abort_m1w",     32'(m1_waitrequest), 32'h0);
        chk("to_abort_m0w",     32'(m0_waitrequest), 32'h1);
        chk("to_abort_m1rdata", m1_readdata, 32'h0);
        chk("to_abort_err",     32'(bus_error), 32'h1);
        chk("to_abort_fp_err",  32'(fp_bus_error), 32'h1);
        chk("to_abort_grant",   32'(grant), 32'h2);
        $display("timeout: bus_error=%b m1w=%b", bus_error, m1_waitrequest);
        tick;
        m1_read     = 1'b0;
        waitrequest = 1'b0;
        #1;
        chk("to_after_grant", 32'(grant), 32'h0);
        chk("to_after_err",   32'(bus_error), 32'h1);
        chk("to_after_m1w",   32'(m1_waitrequest), 32'h1);

        // ---------------- reset during RDATA ----------------
        tick;
        m0_read = 1'b1;
        #1;
        chk("rr_idle_grant", 32'(grant), 32'h0);
        tick;
        chk("rr_bus_read", 32'(read), 32'h1);
        tick;
        readdata = 32'h55AA_55AA;
        #1;
        chk("rr_rdata_m0w",   32'(m0_waitrequest), 32'h0);
        chk("rr_rdata_value", m0_readdata, 32'h55AA_55AA);
        reset = 1'b1;
        #1;
        chk("rr_rst_m0w",     32'(m0_waitrequest), 32'h1);
        chk("rr_rst_m0rdata", m0_readdata, 32'h0);
        chk("rr_rst_grant",   32'(grant), 32'h0);
        chk("rr_rst_err",     32'(bus_error), 32'h0);
        chk("rr_rst_address", address, 32'h0);
        $display("reset in RDATA: m0w=%b grant=%b bus_error=%b", m0_waitrequest, grant, bus_error);
        tick;
        reset   = 1'b0;
        m0_read = 1'b0;
        #1;
        chk("rr_post_m0w",   32'(m0_waitrequest), 32'h1);
        chk("rr_post_grant", 32'(grant), 32'h0);
        chk("rr_post_read",  32'(read), 32'h0);
        tick;
        chk("rr_post2_m0w",  32'(m0_waitrequest), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
